// File: rtl/btb_assoc_pkg.sv
// Shared types for the lc3b branch target buffer: word/counter types, counter
// encodings and the saturating counter step.
package btb_assoc_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_btb_ctr;

  localparam lc3b_btb_ctr BTB_CTR_STRONG_NT = 2'b00;
  localparam lc3b_btb_ctr BTB_CTR_WEAK_NT   = 2'b01;
  localparam lc3b_btb_ctr BTB_CTR_WEAK_T    = 2'b10;
  localparam lc3b_btb_ctr BTB_CTR_STRONG_T  = 2'b11;

  function automatic lc3b_btb_ctr btb_ctr_next(lc3b_btb_ctr ctr, logic taken);
    if (taken) begin
      return (ctr == BTB_CTR_STRONG_T) ? ctr : ctr + 2'd1;
    end
    return (ctr == BTB_CTR_STRONG_NT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_set.sv
// One BTB set: all ways, tag compare, hit-way encode, victim select and the
// true-LRU age update (age 0 = MRU).
module btb_set
  import btb_assoc_pkg::*;
#(
  parameter int unsigned NUM_WAYS = 2,
  parameter int unsigned TAG_W    = 12,
  parameter lc3b_btb_ctr CTR_INIT = BTB_CTR_WEAK_T
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  output lc3b_btb_ctr      hit_ctr,
  output lc3b_word         hit_target,
  input  logic             update_en,
  input  logic [TAG_W-1:0] update_tag,
  input  lc3b_word         update_target,
  input  logic             update_taken
);

  localparam int unsigned AGE_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic             valid_q  [NUM_WAYS];
  logic             valid_d  [NUM_WAYS];
  logic [TAG_W-1:0] tag_q    [NUM_WAYS];
  logic [TAG_W-1:0] tag_d    [NUM_WAYS];
  lc3b_word         target_q [NUM_WAYS];
  lc3b_word         target_d [NUM_WAYS];
  lc3b_btb_ctr      ctr_q    [NUM_WAYS];
  lc3b_btb_ctr      ctr_d    [NUM_WAYS];
  logic [AGE_W-1:0] age_q    [NUM_WAYS];
  logic [AGE_W-1:0] age_d    [NUM_WAYS];

  logic             upd_hit;
  logic [AGE_W-1:0] upd_way;
  logic [AGE_W-1:0] victim;
  logic [AGE_W-1:0] promote_way;
  logic             promote;

  // Descending scan so the lowest-numbered matching way wins.
  always_comb begin
    hit        = 1'b0;
    hit_ctr    = BTB_CTR_STRONG_NT;
    hit_target = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[w] && tag_q[w] == lookup_tag) begin
        hit        = 1'b1;
        hit_ctr    = ctr_q[w];
        hit_target = target_q[w];
      end
    end
  end

  always_comb begin
    upd_hit = 1'b0;
    upd_way = '0;
    victim  = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[w] && tag_q[w] == update_tag) begin
        upd_hit = 1'b1;
        upd_way = AGE_W'(w);
      end
      if (age_q[w] == AGE_W'(NUM_WAYS - 1)) victim = AGE_W'(w);
    end
    // An invalid way always beats the LRU way.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w]) victim = AGE_W'(w);
    end
  end

  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    target_d    = target_q;
    ctr_d       = ctr_q;
    age_d       = age_q;
    promote     = 1'b0;
    promote_way = upd_hit ? upd_way : victim;
    if (flush) begin
      for (int w = 0; w < NUM_WAYS; w++) valid_d[w] = 1'b0;
    end else if (update_en) begin
      if (upd_hit) begin
        ctr_d[upd_way] = btb_ctr_next(ctr_q[upd_way], update_taken);
        if (update_taken) target_d[upd_way] = update_target;
        promote = 1'b1;
      end else if (update_taken) begin
        valid_d[victim]  = 1'b1;
        tag_d[victim]    = update_tag;
        target_d[victim] = update_target;
        ctr_d[victim]    = CTR_INIT;
        promote          = 1'b1;
      end
    end
    if (promote) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (AGE_W'(w) == promote_way) begin
          age_d[w] = '0;
        end else if (age_q[w] < age_q[promote_way]) begin
          age_d[w] = age_q[w] + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        valid_q[w]  <= 1'b0;
        tag_q[w]    <= '0;
        target_q[w] <= '0;
        ctr_q[w]    <= BTB_CTR_WEAK_NT;
        age_q[w]    <= AGE_W'(w);
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
      age_q    <= age_d;
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// N-way set-associative BTB: combinational lookup on the fetch PC, writeback of
// resolved branches through the update port, synchronous flush.
module btb_assoc
  import btb_assoc_pkg::*;
#(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned NUM_WAYS = 2,
  parameter lc3b_btb_ctr CTR_INIT = 2'b10
) (
  input  logic     clk,
  input  logic     rst_n,
  input  lc3b_word curr_pc,
  output logic     pred_hit,
  output logic     pred_taken,
  output lc3b_word pred_target,
  input  logic     update_valid,
  input  lc3b_word update_pc,
  input  lc3b_word update_target,
  input  logic     update_taken,
  input  logic     flush
);

  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 15 - IDX_W;

  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [IDX_W-1:0] update_idx;
  logic [TAG_W-1:0] update_tag;

  // pc[0] is ignored: PCs are word-aligned.
  assign lookup_idx = curr_pc[IDX_W:1];
  assign lookup_tag = curr_pc[15:IDX_W+1];
  assign update_idx = update_pc[IDX_W:1];
  assign update_tag = update_pc[15:IDX_W+1];

  logic        set_hit    [NUM_SETS];
  lc3b_btb_ctr set_ctr    [NUM_SETS];
  lc3b_word    set_target [NUM_SETS];

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    btb_set #(
      .NUM_WAYS (NUM_WAYS),
      .TAG_W    (TAG_W),
      .CTR_INIT (CTR_INIT)
    ) u_set (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .lookup_tag    (lookup_tag),
      .hit           (set_hit[s]),
      .hit_ctr       (set_ctr[s]),
      .hit_target    (set_target[s]),
      .update_en     (update_valid && (update_idx == IDX_W'(s))),
      .update_tag    (update_tag),
      .update_target (update_target),
      .update_taken  (update_taken)
    );
  end

  // Per-set target is already zero on a miss.
  assign pred_hit    = set_hit[lookup_idx];
  assign pred_taken  = pred_hit & set_ctr[lookup_idx][1];
  assign pred_target = set_target[lookup_idx];

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc (NUM_SETS=8, NUM_WAYS=2): stimulus queues
// expected lookups, a negedge monitor pops and compares.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] curr_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        update_valid;
  logic [15:0] update_pc;
  logic [15:0] update_target;
  logic        update_taken;
  logic        flush;
  logic        chk_valid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [15:0] target;
  } exp_t;

  exp_t exp_q[$];

  btb_assoc #(
    .NUM_SETS (8),
    .NUM_WAYS (2),
    .CTR_INIT (2'b10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .curr_pc       (curr_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken),
    .flush         (flush)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got a sample, required an expected entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (pred_hit !== e.hit) begin
          n_fail++;
          $display("FAIL %s.hit: got %b, required %b", e.name, pred_hit, e.hit);
        end
        n_checks++;
        if (pred_taken !== e.taken) begin
          n_fail++;
          $display("FAIL %s.taken: got %b, required %b", e.name, pred_taken, e.taken);
        end
        n_checks++;
        if (pred_target !== e.target) begin
          n_fail++;
          $display("FAIL %s.target: got %h, required %h", e.name, pred_target, e.target);
        end
      end
    end
  end

  task automatic check(input logic [15:0] pc, input logic h, input logic t,
                       input logic [15:0] tgt, input string nm);
    curr_pc = pc;
    exp_q.push_back(exp_t'{nm, h, t, tgt});
    chk_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  task automatic upd(input logic [15:0] pc, input logic [15:0] tgt, input logic taken);
    update_valid  = 1'b1;
    update_pc     = pc;
    update_target = tgt;
    update_taken  = taken;
    @(posedge clk);
    #1;
    update_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    curr_pc       = 16'h3000;
    update_valid  = 1'b0;
    update_pc     = '0;
    update_target = '0;
    update_taken  = 1'b0;
    flush         = 1'b0;
    chk_valid     = 1'b0;
    @(posedge clk);
    #1;
    check(16'h3000, 1'b0, 1'b0, 16'h0000, "in_reset");
    rst_n = 1'b1;
    check(16'h3000, 1'b0, 1'b0, 16'h0000, "after_reset");

    // Allocation and counter walk
    upd(16'h3000, 16'h3040, 1'b1);
    check(16'h3000, 1'b1, 1'b1, 16'h3040, "alloc");
    upd(16'h3000, 16'hdead, 1'b0);
    check(16'h3000, 1'b1, 1'b0, 16'h3040, "nt_ctr1");
    upd(16'h3000, 16'hdead, 1'b0);
    check(16'h3000, 1'b1, 1'b0, 16'h3040, "nt_ctr0");
    upd(16'h3000, 16'hdead, 1'b0);
    upd(16'h3000, 16'h3044, 1'b1);
    check(16'h3000, 1'b1, 1'b0, 16'h3044, "sat_low");
    upd(16'h3000, 16'h3048, 1'b1);
    check(16'h3000, 1'b1, 1'b1, 16'h3048, "ctr2");
    upd(16'h3000, 16'h3048, 1'b1);
    upd(16'h3000, 16'h3048, 1'b1);
    upd(16'h3000, 16'hdead, 1'b0);
    check(16'h3000, 1'b1, 1'b1, 16'h3048, "sat_high");

    // LRU: 3010 fills way 1, touch 3000, 3020 evicts 3010
    upd(16'h3010, 16'h3110, 1'b1);
    check(16'h3010, 1'b1, 1'b1, 16'h3110, "second_way");
    upd(16'h3000, 16'h3048, 1'b1);
    upd(16'h3020, 16'h3120, 1'b1);
    check(16'h3010, 1'b0, 1'b0, 16'h0000, "lru_evicted");
    check(16'h3000, 1'b1, 1'b1, 16'h3048, "lru_kept");
    check(16'h3020, 1'b1, 1'b1, 16'h3120, "lru_new");

    // Same-cycle lookup sees pre-update contents
    update_valid  = 1'b1;
    update_pc     = 16'h4002;
    update_target = 16'h4100;
    update_taken  = 1'b1;
    check(16'h4002, 1'b0, 1'b0, 16'h0000, "same_cycle");
    update_valid = 1'b0;
    check(16'h4002, 1'b1, 1'b1, 16'h4100, "next_cycle");

    // Flush beats a simultaneous update
    flush = 1'b1;
    upd(16'h3000, 16'h3333, 1'b1);
    flush = 1'b0;
    check(16'h3000, 1'b0, 1'b0, 16'h0000, "flush_3000");
    check(16'h3020, 1'b0, 1'b0, 16'h0000, "flush_3020");
    check(16'h4002, 1'b0, 1'b0, 16'h0000, "flush_4002");

    // Reset asserted mid-cycle during an update
    upd(16'h5000, 16'h5100, 1'b1);
    check(16'h5000, 1'b1, 1'b1, 16'h5100, "pre_reset");
    curr_pc       = 16'h5000;
    update_valid  = 1'b1;
    update_pc     = 16'h5002;
    update_target = 16'h5200;
    update_taken  = 1'b1;
    #1;
    rst_n = 1'b0;
    exp_q.push_back(exp_t'{"mid_reset", 1'b0, 1'b0, 16'h0000});
    chk_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_valid    = 1'b0;
    update_valid = 1'b0;
    rst_n        = 1'b1;
    check(16'h5002, 1'b0, 1'b0, 16'h0000, "reset_drop_upd");
    check(16'h5000, 1'b0, 1'b0, 16'h0000, "reset_clear");

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
